// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory port and
// presents instruction/PC to IF/ID, with a one-entry skid buffer and redirect kill.
module instruction_fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_KILL = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  logic [31:0]       slot_instr_q, slot_instr_d;
  logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
  logic              slot_valid_q, slot_valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              skid_valid_q, skid_valid_d;

  logic fetch_ack;
  logic slot_open;

  // KILL keeps the abandoned address on the bus while pc already holds the target.
  assign imem_req    = (state_q == S_REQ) || (state_q == S_KILL);
  assign imem_addr   = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign instruction = slot_instr_q;
  assign pc_out      = slot_pc_q;
  assign instr_valid = slot_valid_q;

  assign fetch_ack = (state_q == S_REQ) && imem_ack;
  assign slot_open = !slot_valid_q || !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_valid_d = slot_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;

    if (redirect_valid) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = redirect_pc & ~ADDR_W'(3);
      unique case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_KILL;
            kill_addr_d = pc_q;
          end
        end
        S_KILL:  state_d = imem_ack ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end else begin
      // Slot refill order: skid contents, then this cycle's fetch data.
      if (slot_open) begin
        if (skid_valid_q) begin
          slot_instr_d = skid_instr_q;
          slot_pc_d    = skid_pc_q;
          slot_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (fetch_ack) begin
          slot_instr_d = imem_rdata;
          slot_pc_d    = pc_q;
          slot_valid_d = 1'b1;
        end else begin
          slot_valid_d = 1'b0;
        end
      end else if (fetch_ack) begin
        skid_instr_d = imem_rdata;
        skid_pc_d    = pc_q;
        skid_valid_d = 1'b1;
      end

      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
            if (!slot_open) state_d = S_HOLD;
          end
        end
        S_HOLD: if (slot_open) state_d = S_REQ;
        S_KILL: if (imem_ack) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_valid_q <= slot_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable memory
// model that returns addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int mem_cnt;

  instruction_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  // Memory acks on the mem_lat-th cycle of a held request (1 = same cycle).
  assign imem_ack   = imem_req && (mem_cnt == mem_lat - 1);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_cnt <= 0;
    else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  // Leaves the bench at the first negedge in REQ at RESET_PC.
  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_lat = lat;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    mem_lat = 1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instruction !== 32'h0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_values got req=%b addr=%h v=%b instr=%h pc=%h exp 0/0/0/0/0",
               imem_req, imem_addr, instr_valid, instruction, pc_out);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got req=%b exp 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req got req=%b addr=%h exp 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp_pc;
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL zw_addr k=%0d got req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      checks++;
      if (instr_valid !== (k > 0)) begin
        errors++;
        $display("FAIL zw_valid k=%0d got %b exp %b", k, instr_valid, (k > 0));
      end
      if (k > 0) begin
        exp_pc = 32'(4 * (k - 1));
        checks++;
        if (pc_out !== exp_pc || instruction !== (exp_pc ^ 32'hA5A5_0000)) begin
          errors++;
          $display("FAIL zw_slot k=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                   k, pc_out, instruction, exp_pc, exp_pc ^ 32'hA5A5_0000);
        end
      end
    end
  endtask

  task automatic test_latency;
    do_reset(3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat_wait k=%0d got req=%b addr=%h v=%b exp 1/0/0", k, imem_req, imem_addr, instr_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL lat_first got v=%b pc=%h addr=%h exp 1/0/4", instr_valid, pc_out, imem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat_gap k=%0d got v=%b exp 0", k, instr_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h4) begin
      errors++;
      $display("FAIL lat_second got v=%b pc=%h exp 1/4", instr_valid, pc_out);
    end
  endtask

  task automatic test_stall_skid;
    do_reset(1);
    repeat (3) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h8 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_pre got v=%b pc=%h addr=%h exp 1/8/c", instr_valid, pc_out, imem_addr);
    end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== 32'h8 || instruction !== 32'hA5A5_0008 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold k=%0d got v=%b pc=%h instr=%h req=%b exp 1/8/a5a50008/0",
                 k, instr_valid, pc_out, instruction, imem_req);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'hC || instruction !== 32'hA5A5_000C ||
        imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_skid_out got v=%b pc=%h instr=%h req=%b addr=%h exp 1/c/a5a5000c/1/10",
               instr_valid, pc_out, instruction, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h10) begin
      errors++;
      $display("FAIL stall_resume got v=%b pc=%h exp 1/10", instr_valid, pc_out);
    end
  endtask

  task automatic test_redirect_kill;
    do_reset(2);
    repeat (16) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || instr_valid !== 1'b1 || pc_out !== 32'h1C) begin
      errors++;
      $display("FAIL kill_pre got req=%b addr=%h v=%b pc=%h exp 1/20/1/1c", imem_req, imem_addr, instr_valid, pc_out);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_state got req=%b addr=%h v=%b exp 1/20/0", imem_req, imem_addr, instr_valid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h1000 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL kill_newreq k=%0d got req=%b addr=%h v=%b exp 1/1000/0", k, imem_req, imem_addr, instr_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h1000 || instruction !== 32'hA5A5_1000) begin
      errors++;
      $display("FAIL kill_first got v=%b pc=%h instr=%h exp 1/1000/a5a51000", instr_valid, pc_out, instruction);
    end
  endtask

  task automatic test_redirect_ack_stall;
    do_reset(1);
    repeat (2) @(negedge clk);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      errors++;
      $display("FAIL rack_flush got v=%b req=%b addr=%h exp 0/1/2000", instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h2000) begin
      errors++;
      $display("FAIL rack_fill got v=%b pc=%h exp 1/2000", instr_valid, pc_out);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h2000 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rack_hold got v=%b pc=%h req=%b exp 1/2000/0", instr_valid, pc_out, imem_req);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
      errors++;
      $display("FAIL rhold_redirect got v=%b req=%b addr=%h exp 0/1/3000", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap;
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_req got addr=%h v=%b exp fffffffc/0", imem_addr, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next got addr=%h pc=%h v=%b exp 0/fffffffc/1", imem_addr, pc_out, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (pc_out !== 32'h0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL wrap_after got pc=%h addr=%h exp 0/4", pc_out, imem_addr);
    end
  endtask

  task automatic test_reset_midop;
    do_reset(3);
    repeat (3) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instruction !== 32'hA5A5_0000 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL mid_pre got v=%b instr=%h req=%b addr=%h exp 1/a5a50000/1/4",
               instr_valid, instruction, imem_req, imem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instruction !== 32'h0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_async got req=%b addr=%h v=%b instr=%h pc=%h exp 0/0/0/0/0",
               imem_req, imem_addr, instr_valid, instruction, pc_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, instr_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_first got v=%b pc=%h exp 1/0", instr_valid, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_skid();
    test_redirect_kill();
    test_redirect_ack_stall();
    test_wrap();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the IF/ID instruction hand-off.
- Owns the program counter, fetches 32-bit instruction words over a req/ack instruction-memory port, and presents instruction + PC with a valid flag to the IF/ID stage.
- Honours a stall from decode and a branch/jump redirect from later stages.
- Contains a one-entry skid buffer so no fetched word is lost while decode is stalled.

Parameters:
- ADDR_W, 32, width of PC and memory address
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, byte increment between sequential instructions

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  decode cannot accept; output slot must hold
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] forced to 0 internally
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  read data valid; sampled only while imem_req=1
- imem_rdata  in  32  instruction word
- instruction  out  32  instruction to IF/ID
- pc_out  out  ADDR_W  address of instruction
- instr_valid  out  1  instruction/pc_out valid

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC.
  - instruction=0, pc_out=0, instr_valid=0; skid buffer empty.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0, waiting for the skid buffer to drain.
  - KILL: imem_req=1 at the stale address; returned data is discarded.
- Memory handshake:
  - Once imem_req is asserted, imem_addr is stable and imem_req stays high until a cycle with imem_ack=1.
  - An ack in the same cycle as the request is legal (zero-wait memory).
  - On ack, pc <= pc+PC_STEP, modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0.
- Output slot:
  - Consumed on any cycle with instr_valid=1 and stall=0.
  - Refill priority on consume or empty slot: skid buffer first, else same-cycle ack data, else instr_valid<=0.
- Skid buffer:
  - If ack arrives while the slot is occupied and not consumed, the data and its address go to the skid buffer and state becomes HOLD.
  - HOLD -> REQ in the cycle the skid contents move into the slot.
  - Both slot and skid full: no request outstanding.
- In REQ with ack and no skid use: state stays REQ, and the next request issues the following cycle at the new pc.
  - Throughput is 1 instruction/cycle with zero-wait memory and no stall.
  - Latency is ack to instr_valid = 1 cycle.
- Redirect (highest priority):
  - On redirect_valid=1, next cycle: instr_valid=0, skid cleared, pc=redirect_pc & ~3.
  - If a request is outstanding and not acked this cycle: go to KILL; keep imem_req high at the old address until ack, discard the data, then REQ at the new pc.
  - Redirect coinciding with ack: data is discarded and the next state is REQ at redirect_pc.
  - Redirect in HOLD or IDLE: next state is REQ.
  - Redirect during KILL: update pc only; remain in KILL.
  - Redirect beats stall: the slot is flushed even if stall=1.
- Stall:
  - Never affects pc or requests except through slot/skid occupancy.
  - While stall=1 with the slot full, instruction and pc_out are held bit-stable.
- Reset mid-operation: immediately returns all outputs to reset values; an outstanding memory transaction is abandoned, and the memory side must tolerate a dropped req.

Test Plan:
- Reset release, zero-wait memory returning addr^32'hA5A5_0000, stall=0 -> imem_addr 0,4,8,… on consecutive cycles; instr_valid high from cycle 3 on; pc_out trails imem_addr by one cycle.
- 3-cycle ack latency -> imem_addr=0 held 3 cycles; a single instr_valid per ack; pc_out 0 then 4.
- stall=1 for 4 cycles with zero-wait memory -> slot holds pc_out=8; the next word (pc 0xC) goes to the skid buffer; imem_req=0 during HOLD; after stall drops, pc_out sequence 8,0xC,0x10 with no gaps or duplicates.
- redirect_valid with redirect_pc=0x0000_1003 while a 2-cycle request to 0x20 is pending -> KILL until ack, 0x20 data never appears; next imem_addr=0x1000; first valid pc_out=0x1000.
- Redirect in the same cycle as ack, with stall=1 -> slot flushed (instr_valid=0 next cycle); next imem_addr=redirect target.
- pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
- rst_n pulsed low mid-request -> outputs return to reset values asynchronously; the fetch restarts at RESET_PC.
